// File: rtl/nl_xbar_pkg.sv
// Shared types and helpers for the one-hot-select crossbar allocator.
// Helpers work on a 32-bit container, so port counts up to 32 are supported.
package nl_xbar_pkg;

  // Per-output allocation state: wormhole lock, locked owner, round-robin pointer
  typedef struct packed {
    logic       lock;
    logic [7:0] owner;
    logic [7:0] ptr;
  } rr_state_t;

  function automatic logic [31:0] idx_to_onehot(input logic [4:0] idx);
    logic [31:0] v;
    v      = 32'd0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [4:0] onehot_to_idx(input logic [31:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) begin
        r = 5'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/nl_rr_lock_arbiter.sv
// Per-output round-robin arbiter with wormhole lock.
// While locked, the owner keeps the output from head flit until its tail transfers.
module nl_rr_lock_arbiter
  import nl_xbar_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] req_tail,
  input  logic         out_ready,
  output logic [N-1:0] sel
);

  localparam int PTR_W = $clog2(N);

  rr_state_t         state_r;
  logic              win_found_s;
  int                win_idx_s;
  int                win_dist_s;
  int                dist_s;
  int                sel_idx_s;
  logic              sel_any_s;
  logic              xfer_s;
  logic              tail_s;
  logic [PTR_W-1:0]  nxt_ptr_s;

  // Round-robin scan: the requester at the smallest distance from ptr wins
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = 0;
    win_dist_s  = N;
    dist_s      = 0;
    for (int i = 0; i < N; i++) begin
      dist_s = (i + N - int'(state_r.ptr)) % N;
      if (req[i] && (dist_s < win_dist_s)) begin
        win_found_s = 1'b1;
        win_idx_s   = i;
        win_dist_s  = dist_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Select the locked owner or the fresh winner; detect a transfer and its tail
  always_comb begin
    if (!rst_n) begin
      sel_any_s = 1'b0;
      sel_idx_s = 0;
    end else if (state_r.lock) begin
      sel_any_s = 1'b1;
      sel_idx_s = int'(state_r.owner);
    end else begin
      sel_any_s = win_found_s;
      sel_idx_s = win_idx_s;
    end
    sel = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      sel[i] = sel_any_s && (sel_idx_s == i);
    end
    xfer_s    = out_ready && (|(sel & req));
    tail_s    = |(sel & req_tail);
    nxt_ptr_s = (sel_idx_s == N - 1) ? {PTR_W{1'b0}} : PTR_W'(sel_idx_s + 1);
  end

  // Lock on a head transfer, release and advance the pointer on a tail transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= '{lock: 1'b0, owner: 8'd0, ptr: 8'd0};
    end else if (xfer_s && tail_s) begin
      state_r.lock <= 1'b0;
      state_r.ptr  <= 8'(nxt_ptr_s);
    end else if (xfer_s && !state_r.lock) begin
      state_r.lock  <= 1'b1;
      state_r.owner <= 8'(sel_idx_s);
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: rtl/nl_crossbar_allocator.sv
// Switch allocator for a one-hot-select crossbar: qualifies per-input requests,
// runs one locking round-robin arbiter per output and derives per-input grants.
module nl_crossbar_allocator
  import nl_xbar_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_valid,
  input  logic [N-1:0][N-1:0] req_port,
  input  logic [N-1:0]        req_tail,
  input  logic [N-1:0]        out_ready,
  output logic [N-1:0][N-1:0] select,
  output logic [N-1:0]        grant,
  output logic                req_err
);

  logic [N-1:0]        req_ok_s;
  logic                req_bad_s;
  logic [N-1:0][N-1:0] req_by_out_s;
  logic [N-1:0]        sel_s [N];
  logic                req_err_r;

  // Keep only valid requests with a one-hot destination; flag malformed ones
  always_comb begin
    req_ok_s  = {N{1'b0}};
    req_bad_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i]) begin
        if (is_onehot(32'(req_port[i]))) begin
          req_ok_s[i] = 1'b1;
        end else begin
          req_bad_s = 1'b1;
        end
      end else begin
        req_ok_s[i] = 1'b0;
      end
    end
  end

  // Transpose requests from per-input to per-output view
  always_comb begin
    req_by_out_s = {(N*N){1'b0}};
    for (int o = 0; o < N; o++) begin
      for (int i = 0; i < N; i++) begin
        req_by_out_s[o][i] = req_ok_s[i] & req_port[i][o];
      end
    end
  end

  for (genvar o = 0; o < N; o++) begin : g_out
    nl_rr_lock_arbiter #(.N(N)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_by_out_s[o]),
      .req_tail  (req_tail),
      .out_ready (out_ready[o]),
      .sel       (sel_s[o])
    );
  end

  // Gather arbiter selects and OR-reduce transfers into per-input grants
  always_comb begin
    select = {(N*N){1'b0}};
    grant  = {N{1'b0}};
    for (int o = 0; o < N; o++) begin
      select[o] = sel_s[o];
      for (int i = 0; i < N; i++) begin
        grant[i] = grant[i] | (sel_s[o][i] & req_by_out_s[o][i] & out_ready[o]);
      end
    end
  end

  // Sticky malformed-request flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_err_r <= 1'b0;
    end else if (req_bad_s) begin
      req_err_r <= 1'b1;
    end else begin
      req_err_r <= req_err_r;
    end
  end

  assign req_err = req_err_r;

endmodule

// File: tb/tb_nl_crossbar_allocator.sv
// Directed self-checking bench for nl_crossbar_allocator (N=4).
module tb_nl_crossbar_allocator;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req_valid;
  logic [3:0][3:0]  req_port;
  logic [3:0]       req_tail;
  logic [3:0]       out_ready;
  logic [3:0][3:0]  select;
  logic [3:0]       grant;
  logic             req_err;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  nl_crossbar_allocator #(.N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_port  (req_port),
    .req_tail  (req_tail),
    .out_ready (out_ready),
    .select    (select),
    .grant     (grant),
    .req_err   (req_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    req_valid = 4'b0000;
    req_port  = 16'h0000;
    req_tail  = 4'b0000;
  endtask

  task automatic set_req(input logic [1:0] i, input logic [3:0] port, input logic tail);
    req_valid[i] = 1'b1;
    req_port[i]  = port;
    req_tail[i]  = tail;
  endtask

  initial begin
    clear_reqs();
    out_ready = 4'b1111;
    rst_n     = 1'b0;

    // Reset with every input requesting output 0
    for (int i = 0; i < 4; i++) set_req(2'(i), 4'b0001, 1'b1);
    tick();
    tick();
    #1;
    check_val("rst_select", 32'(select), 32'h0000);
    check_val("rst_grant", 32'(grant), 32'h0);
    check_val("rst_err", 32'(req_err), 32'h0);
    rst_n = 1'b1;
    #1;
    check_val("rel_select", 32'(select), 32'h0001);
    check_val("rel_grant", 32'(grant), 32'h1);
    tick();
    clear_reqs();
    tick();

    // Round robin on output 2 with single-flit packets from all inputs
    for (int i = 0; i < 4; i++) set_req(2'(i), 4'b0100, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      check_val("rr_select2", 32'(select[2]), 32'(rr_exp[k]));
      check_val("rr_grant", 32'(grant), 32'(rr_exp[k]));
      tick();
    end
    clear_reqs();
    tick();

    // Wormhole: input 1 sends 3 flits to output 3, input 0 contends
    set_req(2'd1, 4'b1000, 1'b0);
    #1;
    check_val("wh_head_sel3", 32'(select[3]), 32'h2);
    check_val("wh_head_grant", 32'(grant), 32'h2);
    tick();
    set_req(2'd0, 4'b1000, 1'b1);
    #1;
    check_val("wh_body_sel3", 32'(select[3]), 32'h2);
    check_val("wh_body_grant", 32'(grant), 32'h2);
    tick();
    req_tail[1] = 1'b1;
    #1;
    check_val("wh_tail_sel3", 32'(select[3]), 32'h2);
    check_val("wh_tail_grant", 32'(grant), 32'h2);
    tick();
    req_valid[1] = 1'b0;
    out_ready[3] = 1'b0;
    #1;
    check_val("wh_after_sel3", 32'(select[3]), 32'h1);
    check_val("wh_after_grant", 32'(grant), 32'h0);
    set_req(2'd3, 4'b1000, 1'b1);
    #1;
    check_val("wh_ptr2_sel3", 32'(select[3]), 32'h8);
    clear_reqs();
    out_ready = 4'b1111;
    tick();

    // Backpressure and owner bubble on output 1
    set_req(2'd2, 4'b0010, 1'b0);
    #1;
    check_val("bp_head_grant", 32'(grant), 32'h4);
    tick();
    set_req(2'd0, 4'b0010, 1'b1);
    out_ready[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check_val("bp_stall_sel1", 32'(select[1]), 32'h4);
      check_val("bp_stall_grant", 32'(grant), 32'h0);
      tick();
    end
    out_ready[1] = 1'b1;
    req_valid[2] = 1'b0;
    #1;
    check_val("bp_bubble_sel1", 32'(select[1]), 32'h4);
    check_val("bp_bubble_grant", 32'(grant), 32'h0);
    tick();
    req_valid[2] = 1'b1;
    #1;
    check_val("bp_body_grant", 32'(grant), 32'h4);
    tick();
    req_tail[2] = 1'b1;
    #1;
    check_val("bp_tail_grant", 32'(grant), 32'h4);
    tick();
    req_valid[2] = 1'b0;
    #1;
    check_val("bp_next_sel1", 32'(select[1]), 32'h1);
    check_val("bp_next_grant", 32'(grant), 32'h1);
    tick();
    clear_reqs();
    tick();

    // Parallel grants plus a malformed request from input 3
    set_req(2'd0, 4'b0010, 1'b1);
    set_req(2'd1, 4'b0001, 1'b1);
    set_req(2'd2, 4'b1000, 1'b1);
    set_req(2'd3, 4'b0101, 1'b1);
    #1;
    check_val("par_grant", 32'(grant), 32'h7);
    check_val("par_select", 32'(select), 32'h4012);
    check_val("par_err_pre", 32'(req_err), 32'h0);
    tick();
    check_val("par_err_set", 32'(req_err), 32'h1);
    clear_reqs();
    tick();
    tick();
    check_val("par_err_sticky", 32'(req_err), 32'h1);

    // Reset in the middle of a packet on output 0
    set_req(2'd1, 4'b0001, 1'b0);
    #1;
    check_val("mr_head_grant", 32'(grant), 32'h2);
    tick();
    req_valid[1] = 1'b0;
    set_req(2'd3, 4'b0001, 1'b1);
    #1;
    check_val("mr_lock_sel0", 32'(select[0]), 32'h2);
    check_val("mr_lock_grant", 32'(grant), 32'h0);
    rst_n = 1'b0;
    #1;
    check_val("mr_rst_select", 32'(select), 32'h0000);
    check_val("mr_rst_grant", 32'(grant), 32'h0);
    tick();
    check_val("mr_rst_err", 32'(req_err), 32'h0);
    rst_n = 1'b1;
    #1;
    check_val("mr_new_select", 32'(select), 32'h0008);
    check_val("mr_new_grant", 32'(grant), 32'h8);
    tick();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
